// File: rtl/add_unit_arbiter.sv
// Purpose : round-robin share of one pipelined adder between NREQ issue slots.
// Latency : ADD_LAT+2 cycles from accept to one-cycle rsp_valid pulse.
// Backpres: one-hot combinational req_ready grant; no stall, no response backpressure.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/a/b        per-slot requests, operands packed at [i*WIDTH +: WIDTH]
//   req_ready            one-hot grant to the selected slot
//   add_a/add_b          registered operands to the shared adder
//   add_sum/add_cout     adder result, valid ADD_LAT cycles after operands
//   rsp_valid/sum/cout   one-hot result pulse plus registered sum and carry
//   busy                 op in the tag pipe or response being presented
module add_unit_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int ADD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] scan_idx;
    logic           gnt_any;
    int             scan;

    // Tag pipe: stage k holds the requester id of the op whose operands
    // entered the adder k cycles ago; the last stage lines up with add_sum.
    logic [ADD_LAT:0] tag_vld;
    logic [IDW-1:0]   tag_id [ADD_LAT+1];

    // Round-robin scan starting at ptr, wrapping modulo NREQ.
    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        gnt_any   = 1'b0;
        scan      = 0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = int'(ptr) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            scan_idx = IDW'(scan);
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_id  = scan_idx;
            end
        end
        // No grant may be shown while reset is asserted.
        if (!rst_n) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            tag_vld   <= '0;
            for (int k = 0; k <= ADD_LAT; k++) begin
                tag_id[k] <= '0;
            end
            rsp_valid <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            if (gnt_any) begin
                ptr   <= ptr_nxt;
                add_a <= req_a[gnt_id*WIDTH +: WIDTH];
                add_b <= req_b[gnt_id*WIDTH +: WIDTH];
            end
            tag_vld[0] <= gnt_any;
            tag_id[0]  <= gnt_id;
            for (int k = 1; k <= ADD_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            // Capture the adder output in the cycle its tag reaches the end.
            rsp_valid <= tag_vld[ADD_LAT] ? (NREQ'(1) << tag_id[ADD_LAT]) : '0;
            if (tag_vld[ADD_LAT]) begin
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
            end
        end
    end

    assign busy = (|tag_vld) | (|rsp_valid);

endmodule
